spi_periph: RTL and testbench



---
 rtl/spi_periph_pkg.sv | 50 +++++
 rtl/spi_periph_sync_edge.sv | 27 ++
 rtl/spi_periph.sv | 156 +++++++++++++++
 tb/tb_spi_periph.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_periph_pkg.sv
// Shared types and constants for the quad-SPI peripheral: commands, FSM states,
// per-command nibble counts and byte masks.
package pkg_spi_periph;

  localparam int DW_C = 32;
  localparam int MW_C = DW_C / 8;

  typedef enum logic [7:0] {
    CMD_WRITE_BT = 8'h01,
    CMD_WRITE_HW = 8'h02,
    CMD_WRITE_WD = 8'h03,
    CMD_READ_BT  = 8'h11,
    CMD_READ_HW  = 8'h12,
    CMD_READ_WD  = 8'h13
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_TURN, ST_RDATA, ST_DONE
  } state_e;

  localparam logic [3:0] NIB_BT = 4'd2;
  localparam logic [3:0] NIB_HW = 4'd4;
  localparam logic [3:0] NIB_WD = 4'd8;

  function automatic logic is_write(input logic [7:0] c);
    return (c == CMD_WRITE_BT) || (c == CMD_WRITE_HW) || (c == CMD_WRITE_WD);
  endfunction

  function automatic logic is_read(input logic [7:0] c);
    return (c == CMD_READ_BT) || (c == CMD_READ_HW) || (c == CMD_READ_WD);
  endfunction

  // Size is carried in the low two command bits for both reads and writes.
  function automatic logic [3:0] nib_count(input logic [7:0] c);
    case (c[1:0])
      2'd1:    return NIB_BT;
      2'd2:    return NIB_HW;
      default: return NIB_WD;
    endcase
  endfunction

  function automatic logic [MW_C-1:0] mask_for(input logic [7:0] c);
    case (c[1:0])
      2'd1:    return 4'b1000;
      2'd2:    return 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/spi_periph_sync_edge.sv
// Two-flop synchronizer with single-clk rise/fall pulses, used for SCK and CS_N.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_periph.sv
// Quad-SPI mode-0 peripheral bridging to a register-file port.
// Optional SPI_PERIPH_AUTOINC_EN: back-to-back units at addr+1 within one frame.
module spi_periph
  import pkg_spi_periph::*;
#(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CS_N,
  input  logic          SCK,
  input  logic [3:0]    COPI,
  output logic [3:0]    CIPO,
  output logic [AW-1:0] addr,
  output logic          we,
  output logic [DW-1:0] wdata,
  output logic [MW-1:0] wmask,
  input  logic [DW-1:0] rdata
);

  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

  spi_sync_edge u_sck (.clk(clk), .rst(rst), .i_d(SCK),  .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_sync_edge u_cs  (.clk(clk), .rst(rst), .i_d(CS_N), .o_rise(w_cs_rise),  .o_fall(w_cs_fall));

  logic [3:0]    r_copi_s1, r_copi_s2;
  state_e        r_state;
  logic [3:0]    r_cnt;
  logic [7:0]    r_cmd;
  logic [DW-5:0] r_sh;
  logic [DW-1:0] r_rsh;
  logic          r_ld_p0, r_ld_p1;
`ifdef SPI_PERIPH_AUTOINC_EN
  logic          r_inc;
`endif

  logic [DW-1:0] w_sh_next, w_rword;
  logic [3:0]    w_n;
  logic          w_last;
  logic [5:0]    w_shamt;

  assign w_sh_next = {r_sh, r_copi_s2};
  assign w_n       = nib_count(r_cmd);
  assign w_last    = (r_cnt == w_n - 4'd1);
  assign w_shamt   = 6'(DW) - {w_n, 2'b00};
  // A refetch landing on the same clk as an SCK fall is forwarded straight out.
  assign w_rword   = r_ld_p1 ? rdata : r_rsh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_copi_s1 <= '0;
      r_copi_s2 <= '0;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_sh      <= '0;
      r_rsh     <= '0;
      r_ld_p0   <= 1'b0;
      r_ld_p1   <= 1'b0;
      CIPO      <= '0;
      addr      <= '0;
      we        <= 1'b0;
      wdata     <= '0;
      wmask     <= '0;
`ifdef SPI_PERIPH_AUTOINC_EN
      r_inc     <= 1'b0;
`endif
    end else begin
      r_copi_s1 <= COPI;
      r_copi_s2 <= r_copi_s1;
      we        <= 1'b0;
      r_ld_p0   <= 1'b0;
      r_ld_p1   <= r_ld_p0;
      if (r_ld_p1) r_rsh <= rdata;

      if (w_cs_rise) begin
        r_state <= ST_IDLE;
        CIPO    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_cs_fall) begin
            r_state <= ST_CMD;
            r_cnt   <= '0;
          end
          ST_CMD: if (w_sck_rise) begin
            r_sh <= w_sh_next[DW-5:0];
            if (r_cnt == 4'd1) begin
              r_cmd   <= w_sh_next[7:0];
              r_cnt   <= '0;
              r_state <= ST_ADDR;
            end else r_cnt <= r_cnt + 4'd1;
          end
          ST_ADDR: if (w_sck_rise) begin
            r_sh <= w_sh_next[DW-5:0];
            if (r_cnt == 4'd1) begin
              addr  <= w_sh_next[AW-1:0];
              r_cnt <= '0;
`ifdef SPI_PERIPH_AUTOINC_EN
              r_inc <= 1'b0;
`endif
              if (is_write(r_cmd)) r_state <= ST_WDATA;
              else if (is_read(r_cmd)) begin
                r_state <= ST_TURN;
                r_ld_p0 <= 1'b1;
              end else r_state <= ST_DONE;
            end else r_cnt <= r_cnt + 4'd1;
          end
          ST_WDATA: if (w_sck_rise) begin
            r_sh <= w_sh_next[DW-5:0];
            if (w_last) begin
              wdata <= w_sh_next << w_shamt;
              wmask <= MW'(mask_for(r_cmd));
              we    <= 1'b1;
              r_cnt <= '0;
`ifdef SPI_PERIPH_AUTOINC_EN
              if (r_inc) addr <= addr + AW'(1);
              r_inc   <= 1'b1;
`else
              r_state <= ST_DONE;
`endif
            end else r_cnt <= r_cnt + 4'd1;
          end
          ST_TURN: if (w_sck_rise) begin
            if (r_cnt == 4'd1) begin
              r_state <= ST_RDATA;
              r_cnt   <= '0;
            end else r_cnt <= r_cnt + 4'd1;
          end
          ST_RDATA: begin
            if (w_sck_fall) begin
              CIPO  <= w_rword[DW-1 -: 4];
              r_rsh <= w_rword << 4;
            end
            if (w_sck_rise) begin
              if (w_last) begin
                r_cnt <= '0;
`ifdef SPI_PERIPH_AUTOINC_EN
                addr    <= addr + AW'(1);
                r_ld_p0 <= 1'b1;
`else
                r_state <= ST_DONE;
                CIPO    <= '0;
`endif
              end else r_cnt <= r_cnt + 4'd1;
            end
          end
          ST_DONE: CIPO <= '0;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_periph.sv
// Directed-vector bench for spi_periph: write and CIPO scoreboards fed by the stimulus.
module tb_spi_periph;

  localparam int HALF = 6;

  logic        clk, rst, CS_N, SCK;
  logic [3:0]  COPI, CIPO;
  logic [7:0]  addr;
  logic        we;
  logic [31:0] wdata, rdata;
  logic [3:0]  wmask;

  spi_periph #(.AW(8), .DW(32), .MW(4)) dut (
    .clk(clk), .rst(rst), .CS_N(CS_N), .SCK(SCK), .COPI(COPI), .CIPO(CIPO),
    .addr(addr), .we(we), .wdata(wdata), .wmask(wmask), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) rdata <= mem[addr];

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  wr_t        exp_wr[$];
  logic [3:0] exp_nib[$];
  logic       rd_phase;
  int         n_vec, n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write-port monitor: every we pulse must match the next queued write.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_we: got addr %h wdata %h expected no write", addr, wdata);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("we_addr",  32'(addr),  32'(e.a));
        check("we_wdata", wdata,      e.d);
        check("we_wmask", 32'(wmask), 32'(e.m));
      end
    end
  end

  // CIPO monitor, sampled where the controller samples it.
  always @(posedge SCK) begin
    if (CS_N === 1'b0) begin
      if (rd_phase) begin
        if (exp_nib.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL cipo_extra: got %h expected no nibble", CIPO);
        end else check("cipo_data", 32'(CIPO), 32'(exp_nib.pop_front()));
      end else check("cipo_zero", 32'(CIPO), 32'h0);
    end
  end

  task automatic sck_cycle(input logic [3:0] nib);
    COPI = nib;
    repeat (HALF) @(negedge clk);
    SCK = 1'b1;
    repeat (HALF) @(negedge clk);
    SCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sck_cycle(b[7:4]);
    sck_cycle(b[3:0]);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    CS_N = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    CS_N = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // data is left-justified; n data nibbles are sent from the top.
  task automatic do_write(input logic [7:0] cmd, input logic [7:0] a, input logic [31:0] data,
                          input int n, input logic [3:0] m);
    wr_t e;
    e.a = a; e.d = data; e.m = m;
    exp_wr.push_back(e);
    frame_begin();
    send_byte(cmd);
    send_byte(a);
    for (int i = 0; i < n; i++) sck_cycle(data[31-4*i -: 4]);
    frame_end();
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [7:0] a, input logic [31:0] exp, input int n);
    frame_begin();
    send_byte(cmd);
    send_byte(a);
    sck_cycle(4'h0);
    sck_cycle(4'h0);
    for (int i = 0; i < n; i++) exp_nib.push_back(exp[31-4*i -: 4]);
    rd_phase = 1'b1;
    for (int i = 0; i < n; i++) sck_cycle(4'h0);
    rd_phase = 1'b0;
    frame_end();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cipo"},  32'(CIPO),  32'h0);
    check({tag, "_addr"},  32'(addr),  32'h0);
    check({tag, "_we"},    32'(we),    32'h0);
    check({tag, "_wdata"}, wdata,      32'h0);
    check({tag, "_wmask"}, 32'(wmask), 32'h0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rd_phase = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[3] = 32'h5500_0000;
    mem[6] = 32'hAABB_0000;
    mem[8] = 32'hCCCC_DDDD;
    rst = 1'b1; CS_N = 1'b1; SCK = 1'b0; COPI = 4'h0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    do_write(8'h01, 8'h03, 32'h5500_0000, 2, 4'b1000);
    do_write(8'h02, 8'h06, 32'hAABB_0000, 4, 4'b1100);
    do_write(8'h03, 8'h08, 32'hCCCC_DDDD, 8, 4'b1111);

    do_read(8'h11, 8'h03, 32'h5500_0000, 2);
    do_read(8'h12, 8'h06, 32'hAABB_0000, 4);
    do_read(8'h13, 8'h08, 32'hCCCC_DDDD, 8);
    check("addr_hold", 32'(addr), 32'h08);

    // Aborted WRITE_WD after 3 data nibbles, then a normal frame.
    frame_begin();
    send_byte(8'h03);
    send_byte(8'h10);
    sck_cycle(4'h1); sck_cycle(4'h2); sck_cycle(4'h3);
    frame_end();
    do_write(8'h01, 8'h21, 32'h9A00_0000, 2, 4'b1000);

    // Unknown command: CIPO stays 0, no write, extra edges ignored.
    frame_begin();
    send_byte(8'h7F);
    send_byte(8'h05);
    for (int i = 0; i < 4; i++) sck_cycle(4'hF);
    frame_end();

    // Reset in the middle of a write frame.
    frame_begin();
    send_byte(8'h03);
    send_byte(8'h08);
    sck_cycle(4'hE); sck_cycle(4'hF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    CS_N = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_write(8'h02, 8'h40, 32'h1234_0000, 4, 4'b1100);

    repeat (20) @(negedge clk);
    while (exp_wr.size() > 0) begin
      wr_t e;
      e = exp_wr.pop_front();
      n_vec++; n_bad++;
      $display("FAIL missing_we: got no write expected addr %h wdata %h", e.a, e.d);
    end
    while (exp_nib.size() > 0) begin
      logic [3:0] nb;
      nb = exp_nib.pop_front();
      n_vec++; n_bad++;
      $display("FAIL missing_nibble: got none expected %h", nb);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
